// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the RV32I memory stage (master) and the data memory (slave).
// Requests are valid/ready; read data returns later on rvalid.
interface mem_access_unit_if #(
    parameter int XLEN = 32
);
    logic                req;
    logic                we;
    logic [XLEN-1:0]     addr;
    logic [XLEN-1:0]     wdata;
    logic [XLEN/8-1:0]   wstrb;
    logic                ready;
    logic                rvalid;
    logic [XLEN-1:0]     rdata;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// RV32I memory stage: store strobes, load extension, variable-latency bus FSM and MEM/WB register.
// Optional MISALIGN_TRAP_EN adds MisalignW and suppresses misaligned accesses.
module mem_access_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC4 = '0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                RegWriteM,
    input  logic                MemWriteM,
    input  logic [1:0]          ResultSrcM,
    input  logic [2:0]          LoadControlM,
    input  logic [2:0]          StoreControlM,
    input  logic [4:0]          rdM,
    input  logic [XLEN-1:0]     ALUResultM,
    input  logic [XLEN-1:0]     WriteDataM,
    input  logic [XLEN-1:0]     PCPlus4M,
    input  logic [XLEN-1:0]     PCTargetM,
    mem_access_unit_if.master   dmem,
    output logic                StallM,
`ifdef MISALIGN_TRAP_EN
    output logic                MisalignW,
`endif
    output logic                RegWriteW,
    output logic [1:0]          ResultSrcW,
    output logic [4:0]          rdW,
    output logic [XLEN-1:0]     ReadDataW,
    output logic [XLEN-1:0]     ALUResultW,
    output logic [XLEN-1:0]     PCPlus4W,
    output logic [XLEN-1:0]     PCTargetW
);

    typedef enum logic {
        IDLE,
        WAIT_RESP
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic            w_mem_op;
    logic            w_store_ok;
    logic            w_misalign;
    logic            w_issue;
    logic [3:0]      w_wstrb;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_data;

    assign w_mem_op   = MemWriteM || (ResultSrcM == 2'b01);
    assign w_store_ok = StoreControlM inside {3'b000, 3'b001, 3'b010};

`ifdef MISALIGN_TRAP_EN
    logic w_half_op;
    logic w_word_op;

    assign w_half_op  = MemWriteM ? (StoreControlM == 3'b001)
                                  : (LoadControlM == 3'b001 || LoadControlM == 3'b101);
    assign w_word_op  = MemWriteM ? (StoreControlM == 3'b010) : (LoadControlM == 3'b010);
    assign w_misalign = w_mem_op && ((w_half_op && ALUResultM[0])
                                  || (w_word_op && ALUResultM[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Unsupported store encodings and trapped misaligned ops never reach the bus.
    assign w_issue = w_mem_op && !w_misalign && (!MemWriteM || w_store_ok);

    always_comb begin
        w_wstrb = 4'b0000;
        if (MemWriteM) begin
            case (StoreControlM)
                3'b000:  w_wstrb = 4'b0001 << ALUResultM[1:0];
                3'b001:  w_wstrb = 4'b0011 << {ALUResultM[1], 1'b0};
                3'b010:  w_wstrb = 4'b1111;
                default: w_wstrb = 4'b0000;
            endcase
        end
    end

    assign dmem.addr  = {ALUResultM[XLEN-1:2], 2'b00};
    assign dmem.wdata = WriteDataM;
    assign dmem.wstrb = w_wstrb;

    always_comb begin
        case (ALUResultM[1:0])
            2'b00:   w_byte = dmem.rdata[7:0];
            2'b01:   w_byte = dmem.rdata[15:8];
            2'b10:   w_byte = dmem.rdata[23:16];
            default: w_byte = dmem.rdata[31:24];
        endcase
        w_half = ALUResultM[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
        case (LoadControlM)
            3'b000:  w_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{(XLEN-16){w_half[15]}}, w_half};
            3'b100:  w_load_data = {{(XLEN-8){1'b0}}, w_byte};
            3'b101:  w_load_data = {{(XLEN-16){1'b0}}, w_half};
            default: w_load_data = dmem.rdata;
        endcase
    end

    // NOTE: reset is synchronous, so it is sampled inside the clocked block like any other input.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Reset also masks the request so nothing reaches the bus while the pipeline is being cleared.
    always_comb begin
        w_next_state = r_state;
        dmem.req     = 1'b0;
        dmem.we      = 1'b0;
        StallM       = 1'b0;
        if (!RST) begin
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        dmem.req = 1'b1;
                        dmem.we  = MemWriteM;
                        if (!dmem.ready) begin
                            StallM = 1'b1;
                        end else if (!MemWriteM) begin
                            StallM       = 1'b1;
                            w_next_state = WAIT_RESP;
                        end
                    end
                end
                WAIT_RESP: begin
                    if (dmem.rvalid) begin
                        w_next_state = IDLE;
                    end else begin
                        StallM = 1'b1;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    // A stall inserts a bubble; the data fields keep their last value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            rdW        <= 5'd0;
            ReadDataW  <= '0;
            ALUResultW <= '0;
            PCPlus4W   <= RESET_PC4;
            PCTargetW  <= '0;
`ifdef MISALIGN_TRAP_EN
            MisalignW  <= 1'b0;
`endif
        end else if (StallM) begin
            RegWriteW  <= 1'b0;
            rdW        <= 5'd0;
`ifdef MISALIGN_TRAP_EN
            MisalignW  <= 1'b0;
`endif
        end else begin
            RegWriteW  <= RegWriteM && !w_misalign;
            ResultSrcW <= ResultSrcM;
            rdW        <= rdM;
            ALUResultW <= ALUResultM;
            PCPlus4W   <= PCPlus4M;
            PCTargetW  <= PCTargetM;
            if (r_state == WAIT_RESP) begin
                ReadDataW <= w_load_data;
            end
`ifdef MISALIGN_TRAP_EN
            MisalignW  <= w_misalign;
`endif
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized instructions and bus latencies
// checked cycle by cycle against a transaction-level model of the memory stage.
module tb_mem_access_unit;

    localparam logic [31:0] RESET_PC4 = 32'h0000_1000;

    typedef struct {
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
        logic [2:0]  lc;
        logic [2:0]  sc;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] pc4;
        logic [31:0] pct;
    } instr_t;

    typedef struct {
        logic        rw;
        logic [1:0]  rs;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] pct;
        logic        mis;
    } wb_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  LoadControlM, StoreControlM;
    logic [4:0]  rdM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M, PCTargetM;
    logic        StallM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  rdW;
    logic [31:0] ReadDataW, ALUResultW, PCPlus4W, PCTargetW;
`ifdef MISALIGN_TRAP_EN
    logic        MisalignW;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    wb_t exp_w;

    mem_access_unit_if dmem ();

    mem_access_unit #(
        .XLEN(32),
        .RESET_PC4(RESET_PC4)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM),
        .LoadControlM(LoadControlM),
        .StoreControlM(StoreControlM),
        .rdM(rdM),
        .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M),
        .PCTargetM(PCTargetM),
        .dmem(dmem),
        .StallM(StallM),
`ifdef MISALIGN_TRAP_EN
        .MisalignW(MisalignW),
`endif
        .RegWriteW(RegWriteW),
        .ResultSrcW(ResultSrcW),
        .rdW(rdW),
        .ReadDataW(ReadDataW),
        .ALUResultW(ALUResultW),
        .PCPlus4W(PCPlus4W),
        .PCTargetW(PCTargetW)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_misaligned(input instr_t i);
`ifdef MISALIGN_TRAP_EN
        bit half, word;
        if (i.mw) begin
            half = (i.sc == 3'd1);
            word = (i.sc == 3'd2);
        end else if (i.rs == 2'd1) begin
            half = (i.lc == 3'd1) || (i.lc == 3'd5);
            word = (i.lc == 3'd2);
        end else begin
            return 1'b0;
        end
        return (half && (i.alu % 2 != 0)) || (word && (i.alu % 4 != 0));
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit issues(input instr_t i);
        if (!(i.mw || i.rs == 2'd1)) return 1'b0;
        if (is_misaligned(i)) return 1'b0;
        if (i.mw && i.sc > 3'd2) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] exp_strb(input instr_t i);
        int lane;
        lane = int'(i.alu % 4);
        if (!i.mw) return 4'h0;
        case (i.sc)
            3'd0:    return 4'(1 << lane);
            3'd1:    return 4'(3 << (2 * (lane / 2)));
            3'd2:    return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] lc, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] b, h;
        b = (d >> (8 * (a % 4))) & 32'hFF;
        h = (d >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (lc)
            3'd0:    return (b >= 32'h80)   ? b - 32'h100   : b;
            3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return d;
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive_m(input instr_t i);
        RegWriteM     = i.rw;
        MemWriteM     = i.mw;
        ResultSrcM    = i.rs;
        LoadControlM  = i.lc;
        StoreControlM = i.sc;
        rdM           = i.rd;
        ALUResultM    = i.alu;
        WriteDataM    = i.wd;
        PCPlus4M      = i.pc4;
        PCTargetM     = i.pct;
    endtask

    task automatic check_w(input string tag);
        check({tag, ".RegWriteW"},  {31'd0, RegWriteW}, {31'd0, exp_w.rw});
        check({tag, ".ResultSrcW"}, {30'd0, ResultSrcW}, {30'd0, exp_w.rs});
        check({tag, ".rdW"},        {27'd0, rdW}, {27'd0, exp_w.rd});
        check({tag, ".ReadDataW"},  ReadDataW, exp_w.rdata);
        check({tag, ".ALUResultW"}, ALUResultW, exp_w.alu);
        check({tag, ".PCPlus4W"},   PCPlus4W, exp_w.pc4);
        check({tag, ".PCTargetW"},  PCTargetW, exp_w.pct);
`ifdef MISALIGN_TRAP_EN
        check({tag, ".MisalignW"},  {31'd0, MisalignW}, {31'd0, exp_w.mis});
`endif
    endtask

    function automatic instr_t mk(input logic rw, input logic mw, input logic [1:0] rs, input logic [2:0] lc,
                                  input logic [2:0] sc, input logic [4:0] rd, input logic [31:0] alu,
                                  input logic [31:0] wd);
        instr_t i;
        i.rw = rw; i.mw = mw; i.rs = rs; i.lc = lc; i.sc = sc; i.rd = rd;
        i.alu = alu; i.wd = wd; i.pc4 = $urandom; i.pct = $urandom;
        return i;
    endfunction

    // One instruction held in M until it retires; acc_wait cycles of ready low, then resp_wait
    // empty response cycles for loads before rvalid carries rd_data.
    task automatic run_instr(input string tag, input instr_t i, input int acc_wait, input int resp_wait,
                             input logic [31:0] rd_data);
        bit iss, ld, last, exp_req;
        int total;
        iss   = issues(i);
        ld    = iss && (i.rs == 2'd1) && !i.mw;
        total = !iss ? 1 : (ld ? acc_wait + 2 + resp_wait : acc_wait + 1);
        for (int c = 0; c < total; c++) begin
            @(negedge CLK);
            drive_m(i);
            dmem.ready  = 1'b0;
            dmem.rvalid = 1'b0;
            dmem.rdata  = $urandom;
            if (iss) begin
                if (c == acc_wait) dmem.ready = 1'b1;
                if (ld && c == total - 1) begin
                    dmem.rvalid = 1'b1;
                    dmem.rdata  = rd_data;
                end
            end else begin
                dmem.rvalid = 1'($urandom % 2);
            end
            last    = (c == total - 1);
            exp_req = iss && (c <= acc_wait);
            #1;
            check({tag, ".StallM"}, {31'd0, StallM}, {31'd0, !last});
            check({tag, ".req"}, {31'd0, dmem.req}, {31'd0, exp_req});
            if (exp_req) begin
                check({tag, ".we"}, {31'd0, dmem.we}, {31'd0, i.mw});
                check({tag, ".addr"}, dmem.addr, i.alu - (i.alu % 4));
                check({tag, ".wdata"}, dmem.wdata, i.wd);
                check({tag, ".wstrb"}, {28'd0, dmem.wstrb}, {28'd0, exp_strb(i)});
            end
            @(posedge CLK);
            #1;
            if (!last) begin
                exp_w.rw  = 1'b0;
                exp_w.rd  = 5'd0;
                exp_w.mis = 1'b0;
            end else begin
                exp_w.mis = is_misaligned(i);
                exp_w.rw  = i.rw && !exp_w.mis;
                exp_w.rs  = i.rs;
                exp_w.rd  = i.rd;
                exp_w.alu = i.alu;
                exp_w.pc4 = i.pc4;
                exp_w.pct = i.pct;
                if (ld) exp_w.rdata = load_ext(i.lc, i.alu, rd_data);
            end
            check_w(tag);
        end
    endtask

    task automatic expect_reset_w();
        exp_w.rw = 1'b0; exp_w.rs = 2'd0; exp_w.rd = 5'd0; exp_w.rdata = 32'd0;
        exp_w.alu = 32'd0; exp_w.pc4 = RESET_PC4; exp_w.pct = 32'd0; exp_w.mis = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        instr_t i;
        instr_t nop;

        nop = mk(1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 5'd0, 32'd0, 32'd0);
        drive_m(nop);
        dmem.ready = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = 32'd0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check("reset.StallM", {31'd0, StallM}, 32'd0);
        check("reset.req", {31'd0, dmem.req}, 32'd0);
        expect_reset_w();
        check_w("reset");
        @(negedge CLK);
        RST = 1'b0;

        // SW to 0x100, accepted immediately
        run_instr("sw", mk(1'b0, 1'b1, 2'd0, 3'd0, 3'd2, 5'd0, 32'h100, 32'hDEAD_BEEF), 0, 0, 32'd0);
        // LB at 0x103, rvalid two cycles after acceptance
        run_instr("lb", mk(1'b1, 1'b0, 2'd1, 3'd0, 3'd0, 5'd7, 32'h103, 32'd0), 0, 1, 32'h8012_3456);
        check("lb.value", ReadDataW, 32'hFFFF_FF80);
        // LHU and SH at 0x202
        run_instr("lhu", mk(1'b1, 1'b0, 2'd1, 3'd5, 3'd0, 5'd9, 32'h202, 32'd0), 1, 0, 32'h8001_1234);
        check("lhu.value", ReadDataW, 32'h0000_8001);
        run_instr("sh", mk(1'b0, 1'b1, 2'd0, 3'd0, 3'd1, 5'd0, 32'h202, 32'h5555_AAAA), 0, 0, 32'd0);
        // Store held off by ready for three cycles
        run_instr("sw_wait", mk(1'b0, 1'b1, 2'd0, 3'd0, 3'd2, 5'd0, 32'h40, 32'h1234_5678), 3, 0, 32'd0);
        // Unsupported store encoding: no request
        run_instr("s_bad", mk(1'b0, 1'b1, 2'd0, 3'd0, 3'd3, 5'd0, 32'h44, 32'h1), 0, 0, 32'd0);
        // Word load at an odd address: trapped or lane-0 depending on build
        run_instr("lw_mis", mk(1'b1, 1'b0, 2'd1, 3'd2, 3'd0, 5'd3, 32'h101, 32'd0), 0, 0, 32'hCAFE_F00D);

        // Reset while a load response is outstanding
        i = mk(1'b1, 1'b0, 2'd1, 3'd2, 3'd0, 5'd5, 32'h300, 32'd0);
        @(negedge CLK);
        drive_m(i);
        dmem.ready = 1'b1; dmem.rvalid = 1'b0;
        #1;
        check("rst_mid.accept_stall", {31'd0, StallM}, 32'd1);
        @(negedge CLK);
        dmem.ready = 1'b0;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        expect_reset_w();
        check_w("rst_mid.reset");
        @(negedge CLK);
        RST = 1'b0;
        i = mk(1'b1, 1'b0, 2'd0, 3'd0, 3'd0, 5'd11, 32'h77, 32'd0);
        drive_m(i);
        dmem.rvalid = 1'b1; dmem.rdata = 32'h9999_9999;
        #1;
        check("rst_mid.late_rvalid_stall", {31'd0, StallM}, 32'd0);
        check("rst_mid.late_rvalid_req", {31'd0, dmem.req}, 32'd0);
        @(posedge CLK);
        #1;
        exp_w.rw = 1'b1; exp_w.rs = 2'd0; exp_w.rd = 5'd11; exp_w.alu = 32'h77;
        exp_w.pc4 = i.pc4; exp_w.pct = i.pct;
        check_w("rst_mid.after");

        // Randomized instruction stream with random bus latencies
        for (int n = 0; n < 200; n++) begin
            logic [2:0] lcs [5];
            lcs = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            i = mk(1'($urandom % 2), ($urandom % 3) == 0, 2'($urandom % 4), lcs[$urandom % 5],
                   3'($urandom % 4), 5'($urandom), $urandom, $urandom);
            run_instr("rand", i, int'($urandom % 4), int'($urandom % 4), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage of the RV32I 5-stage pipeline; consumes the EX/MEM register outputs and drives the data-memory bus.
- Formats store strobes, sign/zero-extends load data and holds the MEM/WB pipeline register.
- A two-state FSM handles a valid/ready data bus with variable latency and raises StallM to the hazard unit while an access is outstanding.

Parameters:
- XLEN, 32, datapath width (only 32 supported)
- RESET_PC4, 32'h0, reset value of PCPlus4W

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  synchronous, active-high reset
- RegWriteM  input  1  register write enable of instruction in M
- MemWriteM  input  1  instruction is a store
- ResultSrcM  input  2  00 ALU, 01 load data, 10 PC+4, 11 PCTarget
- LoadControlM  input  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- StoreControlM  input  3  funct3: 000 SB, 001 SH, 010 SW
- rdM  input  5  destination register
- ALUResultM  input  32  effective address / ALU result
- WriteDataM  input  32  store data, already lane-replicated
- PCPlus4M, PCTargetM  input  32 each  forwarded to WB
- dmem_req  output  1  access request
- dmem_we  output  1  1 = write
- dmem_addr  output  32  word-aligned address {ALUResultM[31:2],2'b00}
- dmem_wdata  output  32  equals WriteDataM
- dmem_wstrb  output  4  byte write strobes (0 for loads)
- dmem_ready  input  1  request accepted this cycle
- dmem_rvalid  input  1  read data valid
- dmem_rdata  input  32  read data
- StallM  output  1  freeze F/D/E stages and EX/MEM register
- RegWriteW  output  1  registered
- ResultSrcW  output  2  registered
- rdW  output  5  registered
- ReadDataW, ALUResultW, PCPlus4W, PCTargetW  output  32 each  registered

Behaviour:
- Memory op = MemWriteM | (ResultSrcM==01). Load = ResultSrcM==01 & !MemWriteM.
- FSM states: IDLE, WAIT_RESP. Reset → IDLE.
- IDLE with a memory op: dmem_req=1 combinationally, dmem_we=MemWriteM.
  - ready=0: StallM=1; stay in IDLE; request held stable.
  - ready=1 and store: done, StallM=0.
  - ready=1 and load: StallM=1; next state WAIT_RESP.
- IDLE with no memory op: dmem_req=0, StallM=0.
- WAIT_RESP: dmem_req=0.
  - rvalid=0: StallM=1.
  - rvalid=1: StallM=0; extended data captured into ReadDataW; next state IDLE.
- rvalid is never expected in the acceptance cycle. rvalid arriving while in IDLE is ignored.
- Store strobes:
  - SB: 4'b0001<<addr[1:0]
  - SH: 4'b0011<<{addr[1],1'b0}
  - SW: 4'b1111
  - other encodings: 0, with no request issued
- Load extension: byte lane addr[1:0], halfword lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- MEM/WB register:
  - When StallM=0, it loads all M fields.
  - When StallM=1, it loads a bubble (RegWriteW=0, rdW=0); the other W fields are held.
- Reset values: all W outputs 0 except PCPlus4W=RESET_PC4.
- Combinational outputs at reset: dmem_req=0, StallM=0.
- Reset mid-access: RST in any state forces IDLE next cycle and clears W. The outstanding response is dropped and a late rvalid is ignored.
- Latency: non-memory and zero-wait store take 1 cycle M→W. A load takes 2 cycles or more.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - Added output MisalignW (1 bit), registered, reset 0.
  - Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - On a misaligned op: no dmem_req, no stall; the instruction passes to W with RegWriteW=0 and MisalignW=1 for one cycle.
- Not defined:
  - No port.
  - Offending low address bits are ignored: halfword uses addr[1], word uses lane 0.

Test Plan:
- SW, ALUResultM=0x100, WriteDataM=0xDEADBEEF, ready=1 → req=1, we=1, addr=0x100, wstrb=1111, StallM=0, RegWriteW=0 next cycle.
- LB at 0x103, rdata=0x80xxxxxx, rvalid 2 cycles after accept → StallM high 2 cycles; ReadDataW=0xFFFFFF80, RegWriteW=1 on the following edge.
- LHU at 0x202, rdata=0x8001xxxx → ReadDataW=0x00008001; SH at 0x202 → wstrb=1100.
- Store with ready low 3 cycles → req, addr and wstrb stable; StallM=1 for 3 cycles; W shows 3 bubbles then the store.
- RST asserted in WAIT_RESP, then rvalid → FSM in IDLE; W outputs zero; the rvalid is ignored; StallM=0.
- With MISALIGN_TRAP_EN: LW at 0x101 → dmem_req=0, MisalignW=1, RegWriteW=0 next cycle.
